// File: rtl/run_detect_arbiter.sv
// Round-robin sharing of one run-length detector between two serial-bit channels.
// Each channel keeps its own run context; hits are registered with saturating counters.
module run_detect_arbiter #(
  parameter int RUN_LEN = 4,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       req,
  input  logic [1:0]       bit_in,
  input  logic [1:0]       ch_clr,
  output logic [1:0]       gnt,
  output logic             hit,
  output logic             hit_ch,
  output logic             hit_val,
  output logic [CNT_W-1:0] hit_cnt0,
  output logic [CNT_W-1:0] hit_cnt1
);

  localparam logic [3:0] RL = 4'(RUN_LEN);

  logic             ptr_q, ptr_d;
  logic [1:0]       last_q, last_d;
  logic [3:0]       len0_q, len0_d;
  logic [3:0]       len1_q, len1_d;
  logic             hit_q, hit_d;
  logic             hit_ch_q, hit_ch_d;
  logic             hit_val_q, hit_val_d;
  logic [CNT_W-1:0] cnt0_q, cnt0_d;
  logic [CNT_W-1:0] cnt1_q, cnt1_d;

  // A clear coinciding with a grant restarts the run with the consumed bit.
  function automatic logic [3:0] next_len(input logic       clr,
                                          input logic [3:0] len,
                                          input logic       b,
                                          input logic       last);
    if (clr || (len == 4'd0) || (b != last)) return 4'd1;
    else if (len < RL)                       return len + 4'd1;
    else                                     return len;
  endfunction

  always_comb begin
    unique case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = ptr_q ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

  always_comb begin
    ptr_d     = ptr_q;
    last_d    = last_q;
    len0_d    = len0_q;
    len1_d    = len1_q;
    cnt0_d    = cnt0_q;
    cnt1_d    = cnt1_q;
    hit_d     = 1'b0;
    hit_ch_d  = hit_ch_q;
    hit_val_d = hit_val_q;

    if (gnt != 2'b00) ptr_d = gnt[1];

    if (gnt[0]) begin
      len0_d    = next_len(ch_clr[0], len0_q, bit_in[0], last_q[0]);
      last_d[0] = bit_in[0];
      if (len0_d == RL) begin
        hit_d     = 1'b1;
        hit_ch_d  = 1'b0;
        hit_val_d = bit_in[0];
        if (cnt0_q != '1) cnt0_d = cnt0_q + 1'b1;
      end
    end else if (ch_clr[0]) begin
      len0_d = '0;
    end

    if (gnt[1]) begin
      len1_d    = next_len(ch_clr[1], len1_q, bit_in[1], last_q[1]);
      last_d[1] = bit_in[1];
      if (len1_d == RL) begin
        hit_d     = 1'b1;
        hit_ch_d  = 1'b1;
        hit_val_d = bit_in[1];
        if (cnt1_q != '1) cnt1_d = cnt1_q + 1'b1;
      end
    end else if (ch_clr[1]) begin
      len1_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q     <= 1'b1;
      last_q    <= '0;
      len0_q    <= '0;
      len1_q    <= '0;
      hit_q     <= 1'b0;
      hit_ch_q  <= 1'b0;
      hit_val_q <= 1'b0;
      cnt0_q    <= '0;
      cnt1_q    <= '0;
    end else begin
      ptr_q     <= ptr_d;
      last_q    <= last_d;
      len0_q    <= len0_d;
      len1_q    <= len1_d;
      hit_q     <= hit_d;
      hit_ch_q  <= hit_ch_d;
      hit_val_q <= hit_val_d;
      cnt0_q    <= cnt0_d;
      cnt1_q    <= cnt1_d;
    end
  end

  assign hit      = hit_q;
  assign hit_ch   = hit_ch_q;
  assign hit_val  = hit_val_q;
  assign hit_cnt0 = cnt0_q;
  assign hit_cnt1 = cnt1_q;

endmodule
